pma_region_table: RTL and testbench

PMA_REGION_TABLE -- requirements
Module: pma_region_table

---
 rtl/pma_pkg.sv | 22 ++
 rtl/pma_rule_match.sv | 14 +
 rtl/pma_region_table.sv | 146 ++++++++++++++
 tb/tb_pma_region_table.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// pma_pkg: attr bit layout, config field codes and rule record shared by the PMA region table.
package pma_pkg;
  localparam int unsigned AttrEn       = 0;
  localparam int unsigned AttrCached   = 1;
  localparam int unsigned AttrNonidem  = 2;
  localparam int unsigned AttrExec     = 3;
  localparam int unsigned AttrLock     = 7;
  localparam int unsigned AttrWidth    = 8;
  localparam int unsigned MaxAddrWidth = 64;
  localparam logic [AttrWidth-1:0] AttrMask = 8'h8F;
  typedef enum logic [1:0] {
    FieldBase    = 2'd0,
    FieldLength  = 2'd1,
    FieldAttr    = 2'd2,
    FieldMissClr = 2'd3
  } field_e;
  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] length;
    logic [AttrWidth-1:0]    attr;
  } rule_t;
endpackage

// File: rtl/pma_rule_match.sv
// pma_rule_match: single-rule comparator; the region end is computed one bit wider so it never wraps.
module pma_rule_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] length,
  input  logic                 en,
  output logic                 match
);
  logic [AddrWidth:0] limit;
  assign limit = {1'b0, base} + {1'b0, length};
  assign match = en && |length && addr >= base && {1'b0, addr} < limit;
endmodule

// File: rtl/pma_region_table.sv
// pma_region_table: configurable address-region attribute table with a 2-stage lookup pipeline
// and a saturating miss counter.
module pma_region_table
  import pma_pkg::*;
#(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned AddrWidth = 64,
  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules*AttrWidth-1:0] RstAttr   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic                 cfg_re_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic                 rsp_cached_o,
  output logic                 rsp_nonidem_o,
  output logic                 rsp_exec_o,
  output logic [IdxWidth-1:0]  rsp_rule_o,
  output logic [31:0]          miss_cnt_o
);
  rule_t rules_q [NrRules];
  rule_t rules_d [NrRules];
  logic [NrRules-1:0] match, cached_v, nonidem_v, exec_v;
  logic [NrRules-1:0] s1_match_q, s1_cached_q, s1_nonidem_q, s1_exec_q;
  logic s1_valid_q, stall, idx_ok, locked, wr_rule, miss_clr, miss_inc;
  logic hit_d, cached_d, nonidem_d, exec_d;
  logic [IdxWidth-1:0] rule_d;
  logic [AddrWidth-1:0] rdata_d;
  logic [31:0] miss_cnt_q;

  assign stall       = rsp_valid_o && !rsp_ready_i;
  assign req_ready_o = !stall;
  assign idx_ok      = 32'(cfg_idx_i) < NrRules;
  assign locked      = idx_ok && rules_q[cfg_idx_i].attr[AttrLock];
  assign wr_rule     = cfg_we_i && cfg_field_i != FieldMissClr && idx_ok && !locked;
  assign miss_clr    = cfg_we_i && cfg_field_i == FieldMissClr;
  assign miss_inc    = rsp_valid_o && rsp_ready_i && !rsp_hit_o;
  assign miss_cnt_o  = miss_cnt_q;

  for (genvar i = 0; i < NrRules; i++) begin : g_rule
    pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
      .addr  (req_addr_i),
      .base  (rules_q[i].base[AddrWidth-1:0]),
      .length(rules_q[i].length[AddrWidth-1:0]),
      .en    (rules_q[i].attr[AttrEn]),
      .match (match[i])
    );
    assign cached_v[i]  = rules_q[i].attr[AttrCached];
    assign nonidem_v[i] = rules_q[i].attr[AttrNonidem];
    assign exec_v[i]    = rules_q[i].attr[AttrExec];
  end

  // Reads see rules_d so a simultaneous write is reflected in the read data.
  always_comb begin
    rules_d = rules_q;
    if (wr_rule) begin
      if (cfg_field_i == FieldBase) rules_d[cfg_idx_i].base = MaxAddrWidth'(cfg_wdata_i);
      if (cfg_field_i == FieldLength) rules_d[cfg_idx_i].length = MaxAddrWidth'(cfg_wdata_i);
      if (cfg_field_i == FieldAttr) rules_d[cfg_idx_i].attr = cfg_wdata_i[AttrWidth-1:0] & AttrMask;
    end
  end

  assign rdata_d = !idx_ok ? '0 :
                   cfg_field_i == FieldBase   ? AddrWidth'(rules_d[cfg_idx_i].base) :
                   cfg_field_i == FieldLength ? AddrWidth'(rules_d[cfg_idx_i].length) :
                   cfg_field_i == FieldAttr   ? AddrWidth'(rules_d[cfg_idx_i].attr) : '0;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit_d     = 1'b0;
    cached_d  = 1'b0;
    nonidem_d = 1'b1;
    exec_d    = 1'b0;
    rule_d    = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        hit_d     = 1'b1;
        cached_d  = s1_cached_q[i];
        nonidem_d = s1_nonidem_q[i];
        exec_d    = s1_exec_q[i];
        rule_d    = IdxWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q    <= 1'b0;
      s1_match_q    <= '0;
      s1_cached_q   <= '0;
      s1_nonidem_q  <= '0;
      s1_exec_q     <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_hit_o     <= 1'b0;
      rsp_cached_o  <= 1'b0;
      rsp_nonidem_o <= 1'b1;
      rsp_exec_o    <= 1'b0;
      rsp_rule_o    <= '0;
    end else if (!stall) begin
      s1_valid_q   <= req_valid_i;
      s1_match_q   <= match;
      s1_cached_q  <= cached_v;
      s1_nonidem_q <= nonidem_v;
      s1_exec_q    <= exec_v;
      rsp_valid_o  <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_hit_o     <= hit_d;
        rsp_cached_o  <= cached_d;
        rsp_nonidem_o <= nonidem_d;
        rsp_exec_o    <= exec_d;
        rsp_rule_o    <= rule_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        rules_q[i] <= '{base:   MaxAddrWidth'(RstBase[i*AddrWidth +: AddrWidth]),
                        length: MaxAddrWidth'(RstLength[i*AddrWidth +: AddrWidth]),
                        attr:   RstAttr[i*AttrWidth +: AttrWidth] & AttrMask};
      end
      cfg_err_o   <= 1'b0;
      cfg_rdata_o <= '0;
      miss_cnt_q  <= '0;
    end else begin
      rules_q    <= rules_d;
      cfg_err_o  <= cfg_we_i && cfg_field_i != FieldMissClr && (!idx_ok || locked);
      if (cfg_re_i) cfg_rdata_o <= rdata_d;
      miss_cnt_q <= miss_clr ? '0 : (miss_inc && !(&miss_cnt_q)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end
  end
endmodule

// File: tb/tb_pma_region_table.sv
// tb_pma_region_table: directed lookups and config accesses; a monitor checks responses from a scoreboard.
module tb_pma_region_table;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_re = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [1:0] cfg_field = '0;
  logic [63:0] cfg_wdata = '0, cfg_rdata;
  logic cfg_err;
  logic req_valid = 1'b0, req_ready;
  logic [63:0] req_addr = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic rsp_hit, rsp_cached, rsp_nonidem, rsp_exec;
  logic [2:0] rsp_rule;
  logic [31:0] miss_cnt;

  typedef struct {
    logic [6:0] payload;
    int         cyc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, nrsp = 0;

  pma_region_table #(.NrRules(6), .AddrWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_we_i(cfg_we), .cfg_re_i(cfg_re), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hit_o(rsp_hit), .rsp_cached_o(rsp_cached), .rsp_nonidem_o(rsp_nonidem),
    .rsp_exec_o(rsp_exec), .rsp_rule_o(rsp_rule), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int f, input logic [63:0] d, input logic exp_err, input string name);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_field = 2'(f); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    chk({name, " err"}, 64'(cfg_err), 64'(exp_err));
    @(negedge clk);
    chk({name, " err pulse end"}, 64'(cfg_err), 64'd0);
  endtask

  task automatic cfg_read(input int idx, input int f, input logic [63:0] exp, input string name);
    cfg_re = 1'b1; cfg_idx = 3'(idx); cfg_field = 2'(f);
    @(negedge clk);
    cfg_re = 1'b0;
    chk(name, cfg_rdata, exp);
  endtask

  task automatic issue(input logic [63:0] a, input logic h, c, n, e, input int r, input bit lat);
    exp_t x;
    req_valid = 1'b1; req_addr = a;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready) begin
        x.payload = {h, c, n, e, 3'(r)};
        x.cyc = lat ? cyc + 2 : -1;
        q.push_back(x);
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("issue accept timeout", 64'd0, 64'd1);
  endtask

  task automatic miss(input logic [63:0] a, input bit lat);
    issue(a, 1'b0, 1'b0, 1'b1, 1'b0, 0, lat);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    logic [6:0] cur, prev = '0;
    bit prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cur = {rsp_hit, rsp_cached, rsp_nonidem, rsp_exec, rsp_rule};
      if (rsp_valid && !rsp_ready && prev_stall) chk("payload held in stall", 64'(cur), 64'(prev));
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("unexpected response", 64'(cur), 64'h7F);
        else begin
          x = q.pop_front();
          chk("response payload", 64'(cur), 64'(x.payload));
          if (x.cyc >= 0) chk("response latency", 64'(cyc), 64'(x.cyc));
          nrsp++;
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_nonidem", 64'(rsp_nonidem), 64'd1);
    chk("reset miss_cnt", 64'(miss_cnt), 64'd0);
    chk("reset cfg_rdata", cfg_rdata, 64'd0);
    chk("reset cfg_err", 64'(cfg_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // Region edges
    cfg_write(0, 0, 64'h8000_0000, 1'b0, "r0 base");
    cfg_write(0, 1, 64'h4000_0000, 1'b0, "r0 len");
    cfg_write(0, 2, 64'h03, 1'b0, "r0 attr");
    issue(64'h8000_0000, 1, 1, 0, 0, 0, 1);
    issue(64'hBFFF_FFFF, 1, 1, 0, 0, 0, 1);
    miss(64'hC000_0000, 1);
    drain();
    chk("miss_cnt after edges", 64'(miss_cnt), 64'd1);
    // Locking
    cfg_write(2, 2, 64'h81, 1'b0, "r2 lock");
    cfg_write(2, 0, 64'h1234, 1'b1, "r2 locked base");
    cfg_read(2, 0, 64'h0, "r2 base unchanged");
    cfg_write(2, 2, 64'h00, 1'b1, "r2 unlock attempt");
    cfg_read(2, 2, 64'h81, "r2 attr still locked");
    // Out-of-range index and write+read together
    cfg_write(7, 0, 64'hABC, 1'b1, "idx7 write");
    cfg_read(7, 0, 64'h0, "idx7 read");
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_idx = 3'd5; cfg_field = 2'd0; cfg_wdata = 64'h5000;
    @(negedge clk);
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("write+read returns new", cfg_rdata, 64'h5000);
    chk("write+read no err", 64'(cfg_err), 64'd0);
    // No-wrap region at top of address space
    cfg_write(4, 0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, "r4 base");
    cfg_write(4, 1, 64'h2000, 1'b0, "r4 len");
    cfg_write(4, 2, 64'h01, 1'b0, "r4 attr");
    miss(64'h0, 1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 4, 1);
    drain();
    // Overlap priority
    cfg_write(1, 1, 64'h1_0000, 1'b0, "r1 len");
    cfg_write(1, 2, 64'h09, 1'b0, "r1 attr");
    cfg_write(3, 1, 64'h1000, 1'b0, "r3 len");
    cfg_write(3, 2, 64'h05, 1'b0, "r3 attr");
    cfg_read(3, 1, 64'h1000, "r3 len readback");
    issue(64'h800, 1, 0, 0, 1, 1, 1);
    issue(64'h8000, 1, 0, 0, 1, 1, 1);
    drain();
    // Backpressure
    nrsp = 0;
    fork
      begin
        issue(64'h8000_0000, 1, 1, 0, 0, 0, 0);
        issue(64'h800, 1, 0, 0, 1, 1, 0);
        issue(64'h9000_0000, 1, 1, 0, 0, 0, 0);
        miss(64'h7000_0000, 0);
        issue(64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0, 0, 4, 0);
        miss(64'h2_0000, 0);
      end
      begin
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("req_ready low in stall", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("backpressure response count", 64'(nrsp), 64'd6);
    chk("miss_cnt after burst", 64'(miss_cnt), 64'd4);
    // Saturation and clear priority
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt_q;
    @(negedge clk);
    chk("miss_cnt preset", 64'(miss_cnt), 64'hFFFF_FFFE);
    miss(64'h3000_0000, 1);
    miss(64'h3000_0100, 1);
    miss(64'h3000_0200, 1);
    drain();
    chk("miss_cnt saturated", 64'(miss_cnt), 64'hFFFF_FFFF);
    miss(64'h3000_0300, 1);
    @(negedge clk);
    cfg_we = 1'b1; cfg_field = 2'd3; cfg_idx = 3'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("clear beats increment", 64'(miss_cnt), 64'd0);
    miss(64'h3000_0400, 1);
    drain();
    chk("miss_cnt after clear", 64'(miss_cnt), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
